// File: rtl/picorv32_rr_mem_arbiter.sv
// Round-robin arbiter: CORES_COUNT picorv32 native memory ports -> one
// registered native port that feeds picorv32_axi_adapter.
//
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   mem_*_i[i]        per-core request (valid/instr/addr/wdata/wstrb)
//   mem_ready_o[i]    per-core completion pulse (combinational from mem_ready_i)
//   mem_rdata_o[i]    per-core read data (broadcast of mem_rdata_i)
//   mem_*_o           downstream request, registered at grant time
//   mem_ready_i       downstream completion
//   mem_rdata_i       downstream read data
//   grant_o           index of current / last granted core
//   busy_o            high while a downstream transaction is open
//
// Optional feature macro: ARB_INSTR_PRIO_EN
//   defined   -> instruction fetches win over data accesses in IDLE;
//                round-robin applies within the winning class
//   undefined -> pure round-robin, mem_instr_i ignored for arbitration

module picorv32_rr_mem_arbiter #(
    parameter int CORES_COUNT = 2,
    localparam int GRANT_W = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1
) (
    input  logic               clk,
    input  logic               resetn,

    input  logic               mem_valid_i [CORES_COUNT],
    input  logic               mem_instr_i [CORES_COUNT],
    input  logic [31:0]        mem_addr_i  [CORES_COUNT],
    input  logic [31:0]        mem_wdata_i [CORES_COUNT],
    input  logic [3:0]         mem_wstrb_i [CORES_COUNT],
    output logic               mem_ready_o [CORES_COUNT],
    output logic [31:0]        mem_rdata_o [CORES_COUNT],

    output logic               mem_valid_o,
    output logic               mem_instr_o,
    output logic [31:0]        mem_addr_o,
    output logic [31:0]        mem_wdata_o,
    output logic [3:0]         mem_wstrb_o,
    input  logic               mem_ready_i,
    input  logic [31:0]        mem_rdata_i,

    output logic [GRANT_W-1:0] grant_o,
    output logic               busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [GRANT_W-1:0] last_q, last_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;
    logic               instr_q, instr_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    // Set once the granted core lets go of valid; its completion is then
    // swallowed even if the core re-raises valid before mem_ready_i.
    logic               drop_q, drop_d;

    logic               pick_found;
    logic [GRANT_W-1:0] pick_idx;
    logic               cand_ok;
    int                 scan_idx;
`ifdef ARB_INSTR_PRIO_EN
    logic               any_instr;
`endif

    // ------------------------------------------------------------------
    // Requester selection: scan last+1, last+2, ... modulo CORES_COUNT,
    // first eligible requester wins.
    // ------------------------------------------------------------------
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_ok    = 1'b0;
        scan_idx   = 0;
`ifdef ARB_INSTR_PRIO_EN
        any_instr  = 1'b0;
        for (int i = 0; i < CORES_COUNT; i++) begin
            if (mem_valid_i[i] && mem_instr_i[i]) begin
                any_instr = 1'b1;
            end
        end
`endif
        for (int k = 1; k <= CORES_COUNT; k++) begin
            scan_idx = (int'(last_q) + k) % CORES_COUNT;
`ifdef ARB_INSTR_PRIO_EN
            // Data requesters are only eligible when no fetch is pending.
            cand_ok = mem_valid_i[scan_idx] &&
                      (mem_instr_i[scan_idx] || !any_instr);
`else
            cand_ok = mem_valid_i[scan_idx];
`endif
            if (!pick_found && cand_ok) begin
                pick_found = 1'b1;
                pick_idx   = GRANT_W'(scan_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        valid_d = valid_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        drop_d  = drop_q;

        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                drop_d  = 1'b0;
                if (pick_found) begin
                    grant_d = pick_idx;
                    instr_d = mem_instr_i[pick_idx];
                    addr_d  = mem_addr_i[pick_idx];
                    wdata_d = mem_wdata_i[pick_idx];
                    wstrb_d = mem_wstrb_i[pick_idx];
                    valid_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!mem_valid_i[grant_q]) begin
                    drop_d = 1'b1;
                end
                // The downstream transaction cannot be aborted, so the
                // FSM always waits for mem_ready_i before leaving BUSY.
                if (mem_ready_i) begin
                    valid_d = 1'b0;
                    last_d  = grant_q;
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            last_q  <= GRANT_W'(CORES_COUNT - 1);
            grant_q <= '0;
            valid_q <= 1'b0;
            instr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            drop_q  <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Upstream responses
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < CORES_COUNT; i++) begin
            mem_rdata_o[i] = mem_rdata_i;
            mem_ready_o[i] = (state_q == BUSY) &&
                             (grant_q == GRANT_W'(i)) &&
                             mem_ready_i &&
                             mem_valid_i[i] &&
                             !drop_q;
        end
    end

    assign mem_valid_o = valid_q;
    assign mem_instr_o = instr_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q == BUSY);

endmodule

// File: tb/tb_picorv32_rr_mem_arbiter.sv
// Bench for picorv32_rr_mem_arbiter: table of single transactions plus
// hand sequences (fairness, queued write, abandon, reset, fetch priority).
module tb_picorv32_rr_mem_arbiter;

    localparam int N  = 4;
    localparam int GW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          mem_valid_i [N];
    logic          mem_instr_i [N];
    logic [31:0]   mem_addr_i  [N];
    logic [31:0]   mem_wdata_i [N];
    logic [3:0]    mem_wstrb_i [N];
    logic          mem_ready_o [N];
    logic [31:0]   mem_rdata_o [N];
    logic          mem_valid_o;
    logic          mem_instr_o;
    logic [31:0]   mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_wstrb_o;
    logic          mem_ready_i = 1'b0;
    logic [31:0]   mem_rdata_i = '0;
    logic [GW-1:0] grant_o;
    logic          busy_o;

    picorv32_rr_mem_arbiter #(.CORES_COUNT(N)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_valid_i (mem_valid_i),
        .mem_instr_i (mem_instr_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_ready_o (mem_ready_o),
        .mem_rdata_o (mem_rdata_o),
        .mem_valid_o (mem_valid_o),
        .mem_instr_o (mem_instr_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        rdy;
    } txn_t;

    typedef struct {
        int          core;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
    } vec_t;

    txn_t core_q0[$], core_q1[$], core_q2[$], core_q3[$];
    txn_t exp_q[$];
    txn_t cq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 1;
    int rcnt = 0;
    bit stall = 1'b0;
    bit chk_lat = 1'b0;
    bit done_f [N];
    int drive_cyc [N];

    function automatic logic [31:0] resp_of(input logic [31:0] a);
        if (a == 32'h100) return 32'hCAFE_BABE;
        return (a ^ 32'h5A5A_0000) + 32'd1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic txn_t mk(input int c, input logic ins,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] ws, input logic r);
        txn_t t;
        t.core = c; t.instr = ins; t.addr = a;
        t.wdata = wd; t.wstrb = ws; t.rdy = r;
        return t;
    endfunction

    task automatic push_core(input txn_t t);
        case (t.core)
            0: core_q0.push_back(t);
            1: core_q1.push_back(t);
            2: core_q2.push_back(t);
            default: core_q3.push_back(t);
        endcase
    endtask

    always @(posedge clk) cyc++;

    // Core models: hold valid until ready, then issue the next queued request.
    always @(posedge clk) begin : cores
        txn_t t;
        bit   have;
        #1;
        for (int i = 0; i < N; i++) begin
            if (done_f[i]) begin
                mem_valid_i[i] = 1'b0;
                done_f[i] = 1'b0;
            end
            have = 1'b0;
            if (!mem_valid_i[i]) begin
                case (i)
                    0: if (core_q0.size() > 0) begin t = core_q0.pop_front(); have = 1'b1; end
                    1: if (core_q1.size() > 0) begin t = core_q1.pop_front(); have = 1'b1; end
                    2: if (core_q2.size() > 0) begin t = core_q2.pop_front(); have = 1'b1; end
                    default: if (core_q3.size() > 0) begin t = core_q3.pop_front(); have = 1'b1; end
                endcase
            end
            if (have) begin
                mem_instr_i[i] = t.instr;
                mem_addr_i[i]  = t.addr;
                mem_wdata_i[i] = t.wdata;
                mem_wstrb_i[i] = t.wstrb;
                mem_valid_i[i] = 1'b1;
                drive_cyc[i]   = cyc;
            end
        end
    end

    // Downstream responder: ready 'lat' cycles after valid, one-cycle pulse.
    always @(posedge clk) begin
        #1;
        if (!resetn) begin
            mem_ready_i = 1'b0;
            rcnt = 0;
        end else if (mem_ready_i) begin
            mem_ready_i = 1'b0;
            rcnt = 0;
        end else if (mem_valid_o && !stall) begin
            if (rcnt >= lat) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = resp_of(mem_addr_o);
            end else begin
                rcnt++;
            end
        end
    end

    // Monitor / scoreboard
    logic        prev_v = 1'b0;
    bit          exp_low = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_instr;
    logic [GW-1:0] cap_grant;

    always @(negedge clk) begin : mon
        txn_t e;
        logic any_rdy;
        if (!resetn) begin
            prev_v  = 1'b0;
            exp_low = 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                if (mem_ready_o[i]) done_f[i] = 1'b1;
            if (exp_low) begin
                chk("bubble_valid", 32'(mem_valid_o), 32'd0);
                chk("bubble_busy", 32'(busy_o), 32'd0);
                exp_low = 1'b0;
            end
            if (mem_valid_o && !prev_v) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant_unexpected: got core %0d want none", grant_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", 32'(grant_o), 32'(e.core));
                    chk("addr", mem_addr_o, e.addr);
                    chk("wdata", mem_wdata_o, e.wdata);
                    chk("wstrb", 32'(mem_wstrb_o), 32'(e.wstrb));
                    chk("instr", 32'(mem_instr_o), 32'(e.instr));
                    chk("busy", 32'(busy_o), 32'd1);
                    if (chk_lat)
                        chk("latency", 32'(cyc - drive_cyc[e.core]), 32'd1);
                    cq.push_back(e);
                end
                cap_addr = mem_addr_o; cap_wdata = mem_wdata_o;
                cap_wstrb = mem_wstrb_o; cap_instr = mem_instr_o;
                cap_grant = grant_o;
            end else if (mem_valid_o) begin
                chk("hold_addr", mem_addr_o, cap_addr);
                chk("hold_wdata", mem_wdata_o, cap_wdata);
                chk("hold_wstrb", 32'(mem_wstrb_o), 32'(cap_wstrb));
                chk("hold_instr_grant", {30'd0, mem_instr_o, grant_o == cap_grant},
                    {30'd0, cap_instr, 1'b1});
            end
            if (mem_valid_o && mem_ready_i) begin
                if (cq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL completion_unexpected: got ready want none");
                end else begin
                    e = cq.pop_front();
                    for (int i = 0; i < N; i++)
                        chk($sformatf("ready_o[%0d]", i), 32'(mem_ready_o[i]),
                            32'(e.rdy && (i == e.core)));
                    if (e.rdy)
                        chk("rdata", mem_rdata_o[e.core], resp_of(e.addr));
                    exp_low = 1'b1;
                end
            end else begin
                any_rdy = 1'b0;
                for (int i = 0; i < N; i++) any_rdy |= mem_ready_o[i];
                chk("no_ready", 32'(any_rdy), 32'd0);
            end
            prev_v = mem_valid_o;
        end
    end

    task automatic wait_done(input int budget, input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL %s_timeout: got pending=%0d want 0", nm,
                     exp_q.size() + cq.size());
            exp_q.delete();
            cq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_busy(input int budget, input string nm);
        int n;
        n = 0;
        while (!busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL %s_busy_timeout: got busy=0 want 1", nm);
        end
    endtask

    vec_t tv [7];

    initial begin : main
        tv[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 1};
        tv[1] = '{1, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'hF, 0};
        tv[2] = '{2, 1'b1, 32'h0000_3004, 32'h0,         4'h0, 2};
        tv[3] = '{0, 1'b0, 32'h0000_0044, 32'hAABB_CCDD, 4'h1, 0};
        tv[4] = '{3, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1};
        tv[5] = '{1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 3};
        tv[6] = '{3, 1'b0, 32'h0000_4008, 32'hDEAD_BEEF, 4'hC, 0};

        for (int i = 0; i < N; i++) begin
            mem_valid_i[i] = 1'b0; mem_instr_i[i] = 1'b0;
            mem_addr_i[i] = '0; mem_wdata_i[i] = '0; mem_wstrb_i[i] = '0;
            done_f[i] = 1'b0; drive_cyc[i] = 0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(mem_valid_o), 32'd0);
        chk("rst_instr", 32'(mem_instr_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);

        // Table: isolated transactions, grant latency 1 from idle.
        chk_lat = 1'b1;
        for (int v = 0; v < 7; v++) begin
            txn_t t;
            lat = tv[v].lat;
            t = mk(tv[v].core, tv[v].instr, tv[v].addr, tv[v].wdata,
                   tv[v].wstrb, 1'b1);
            exp_q.push_back(t);
            push_core(t);
            wait_done(60, "table");
        end
        chk_lat = 1'b0;

        // Fairness: all four cores request continuously (last = 3).
        lat = 2;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < N; c++)
                push_core(mk(c, 1'b0, 32'h1000 + 32'(r * 16 + c * 4),
                             32'h0, 4'h0, 1'b1));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < N; c++)
                exp_q.push_back(mk(c, 1'b0, 32'h1000 + 32'(r * 16 + c * 4),
                                   32'h0, 4'h0, 1'b1));
        wait_done(300, "fair");

        // Write from core1 arrives while core0 is busy.
        lat = 3;
        push_core(mk(0, 1'b0, 32'h500, 32'h0, 4'h0, 1'b1));
        exp_q.push_back(mk(0, 1'b0, 32'h500, 32'h0, 4'h0, 1'b1));
        wait_busy(20, "queued");
        push_core(mk(1, 1'b0, 32'h2000, 32'h1234_5678, 4'hF, 1'b1));
        exp_q.push_back(mk(1, 1'b0, 32'h2000, 32'h1234_5678, 4'hF, 1'b1));
        wait_done(60, "queued");

        // Core2 abandons its request mid-transaction.
        lat = 3;
        push_core(mk(2, 1'b0, 32'h600, 32'h0, 4'h0, 1'b1));
        exp_q.push_back(mk(2, 1'b0, 32'h600, 32'h0, 4'h0, 1'b0));
        wait_busy(20, "abandon");
        @(posedge clk); #2 mem_valid_i[2] = 1'b0;
        wait_done(60, "abandon");
        chk("abandon_idle", 32'(busy_o), 32'd0);

        // Reset while busy: core1 done first so last = 1 before reset.
        lat = 0;
        push_core(mk(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1));
        exp_q.push_back(mk(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1));
        wait_done(30, "pre_rst");
        stall = 1'b1;
        push_core(mk(2, 1'b0, 32'h700, 32'h0, 4'h0, 1'b1));
        exp_q.push_back(mk(2, 1'b0, 32'h700, 32'h0, 4'h0, 1'b1));
        wait_busy(20, "rst");
        @(posedge clk); #2 resetn = 1'b0;
        #1;
        chk("midrst_valid", 32'(mem_valid_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_grant", 32'(grant_o), 32'd0);
        chk("midrst_ready2", 32'(mem_ready_o[2]), 32'd0);
        exp_q.delete();
        cq.delete();
        push_core(mk(0, 1'b0, 32'h800, 32'h0, 4'h0, 1'b1));
        exp_q.push_back(mk(0, 1'b0, 32'h800, 32'h0, 4'h0, 1'b1));
        exp_q.push_back(mk(2, 1'b0, 32'h700, 32'h0, 4'h0, 1'b1));
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        wait_done(60, "post_rst");

        // Fetch vs data with last = 3.
        lat = 0;
        push_core(mk(3, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1));
        exp_q.push_back(mk(3, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1));
        wait_done(30, "pre_prio");
        push_core(mk(0, 1'b0, 32'h900, 32'h0, 4'h0, 1'b1));
        push_core(mk(3, 1'b1, 32'hA00, 32'h0, 4'h0, 1'b1));
`ifdef ARB_INSTR_PRIO_EN
        exp_q.push_back(mk(3, 1'b1, 32'hA00, 32'h0, 4'h0, 1'b1));
        exp_q.push_back(mk(0, 1'b0, 32'h900, 32'h0, 4'h0, 1'b1));
`else
        exp_q.push_back(mk(0, 1'b0, 32'h900, 32'h0, 4'h0, 1'b1));
        exp_q.push_back(mk(3, 1'b1, 32'hA00, 32'h0, 4'h0, 1'b1));
`endif
        wait_done(60, "prio");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
